// File: rtl/phaser_in_tap_ctrl.sv
// rtl/phaser_in_tap_ctrl.sv - PHASER_IN delay-control command sequencer
// Turns fine-step / counter-load / counter-read commands into correctly spaced PHASER_IN pin pulses.
module phaser_in_tap_ctrl #(
   parameter int SETTLE_CYCLES = 8,
   parameter int READ_LATENCY  = 4,
   parameter int INIT_FINE_TAP = 0
) (
   input  logic       SYSCLK,
   input  logic       RST,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD_OP,
   input  logic [5:0] CMD_ARG,
   output logic       RSP_VALID,
   output logic [5:0] RSP_DATA,
   output logic       RSP_ERR,
   output logic       BUSY,
   output logic [5:0] FINE_TAP,
   output logic       FINEENABLE,
   output logic       FINEINC,
   output logic       COUNTERLOADEN,
   output logic [5:0] COUNTERLOADVAL,
   output logic       COUNTERREADEN,
   input  logic [5:0] COUNTERREADVAL,
   input  logic       FINEOVERFLOW
);

   localparam logic [1:0] OP_LOAD     = 2'b10;
   localparam logic [1:0] OP_READ     = 2'b11;
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] READ_LAST   = 8'(READ_LATENCY - 1);
   localparam logic [5:0] TAP_INIT    = 6'(INIT_FINE_TAP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FINE_PULSE,
      S_FINE_WAIT,
      S_LOAD_PULSE,
      S_LOAD_WAIT,
      S_READ_PULSE,
      S_READ_WAIT,
      S_RESP
   } state_t;

   state_t     state, state_nxt;
   logic [5:0] remaining, remaining_nxt;
   logic       dir, dir_nxt;
   logic       fine_cmd, fine_cmd_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic [5:0] tap_nxt;
   logic [5:0] load_val_nxt;
   logic [5:0] rsp_data_nxt;
   logic       rsp_err_nxt;

   function automatic logic at_limit(input logic [5:0] tap, input logic up);
      return up ? (tap == 6'd63) : (tap == 6'd0);
   endfunction

   function automatic logic [5:0] tap_step(input logic [5:0] tap, input logic up);
      return up ? tap + 6'd1 : tap - 6'd1;
   endfunction

   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      dir_nxt       = dir;
      fine_cmd_nxt  = fine_cmd;
      wait_nxt      = wait_cnt;
      tap_nxt       = FINE_TAP;
      load_val_nxt  = COUNTERLOADVAL;
      rsp_data_nxt  = RSP_DATA;
      rsp_err_nxt   = RSP_ERR;

      case (state)
         S_IDLE: begin
            if (CMD_VALID) begin
               if (CMD_OP == OP_LOAD) begin
                  fine_cmd_nxt = 1'b0;
                  load_val_nxt = CMD_ARG;
                  state_nxt    = S_LOAD_PULSE;
               end else if (CMD_OP == OP_READ) begin
                  fine_cmd_nxt = 1'b0;
                  state_nxt    = S_READ_PULSE;
               end else begin
                  fine_cmd_nxt = 1'b1;
                  dir_nxt      = ~CMD_OP[0];
                  // Nothing to do, or already pinned at the end of the delay line.
                  if (CMD_ARG == 6'd0 || at_limit(FINE_TAP, ~CMD_OP[0])) begin
                     rsp_data_nxt = FINE_TAP;
                     rsp_err_nxt  = (CMD_ARG != 6'd0);
                     state_nxt    = S_RESP;
                  end else begin
                     tap_nxt       = tap_step(FINE_TAP, ~CMD_OP[0]);
                     remaining_nxt = CMD_ARG - 6'd1;
                     state_nxt     = S_FINE_PULSE;
                  end
               end
            end
         end

         S_FINE_PULSE: begin
            if (FINEOVERFLOW) begin
               rsp_data_nxt = FINE_TAP;
               rsp_err_nxt  = 1'b1;
               state_nxt    = S_RESP;
            end else begin
               wait_nxt  = SETTLE_LAST;
               state_nxt = S_FINE_WAIT;
            end
         end

         S_FINE_WAIT: begin
            if (FINEOVERFLOW) begin
               rsp_data_nxt = FINE_TAP;
               rsp_err_nxt  = 1'b1;
               state_nxt    = S_RESP;
            end else if (wait_cnt != 8'd0) begin
               wait_nxt = wait_cnt - 8'd1;
            end else if (remaining == 6'd0) begin
               rsp_data_nxt = FINE_TAP;
               rsp_err_nxt  = 1'b0;
               state_nxt    = S_RESP;
            end else if (at_limit(FINE_TAP, dir)) begin
               rsp_data_nxt = FINE_TAP;
               rsp_err_nxt  = 1'b1;
               state_nxt    = S_RESP;
            end else begin
               tap_nxt       = tap_step(FINE_TAP, dir);
               remaining_nxt = remaining - 6'd1;
               state_nxt     = S_FINE_PULSE;
            end
         end

         S_LOAD_PULSE: begin
            wait_nxt  = SETTLE_LAST;
            state_nxt = S_LOAD_WAIT;
         end

         S_LOAD_WAIT: begin
            if (wait_cnt != 8'd0) begin
               wait_nxt = wait_cnt - 8'd1;
            end else begin
               rsp_data_nxt = COUNTERLOADVAL;
               rsp_err_nxt  = 1'b0;
               state_nxt    = S_RESP;
            end
         end

         S_READ_PULSE: begin
            wait_nxt  = READ_LAST;
            state_nxt = S_READ_WAIT;
         end

         S_READ_WAIT: begin
            if (wait_cnt != 8'd0) begin
               wait_nxt = wait_cnt - 8'd1;
            end else begin
               rsp_data_nxt = COUNTERREADVAL;
               rsp_err_nxt  = 1'b0;
               state_nxt    = S_RESP;
            end
         end

         S_RESP: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Pin and status outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         remaining      <= 6'd0;
         dir            <= 1'b0;
         fine_cmd       <= 1'b0;
         wait_cnt       <= 8'd0;
         FINE_TAP       <= TAP_INIT;
         COUNTERLOADVAL <= 6'd0;
         RSP_DATA       <= 6'd0;
         RSP_ERR        <= 1'b0;
         RSP_VALID      <= 1'b0;
         CMD_READY      <= 1'b1;
         BUSY           <= 1'b0;
         FINEENABLE     <= 1'b0;
         FINEINC        <= 1'b0;
         COUNTERLOADEN  <= 1'b0;
         COUNTERREADEN  <= 1'b0;
      end else begin
         remaining      <= remaining_nxt;
         dir            <= dir_nxt;
         fine_cmd       <= fine_cmd_nxt;
         wait_cnt       <= wait_nxt;
         FINE_TAP       <= tap_nxt;
         COUNTERLOADVAL <= load_val_nxt;
         RSP_DATA       <= rsp_data_nxt;
         RSP_ERR        <= rsp_err_nxt;
         RSP_VALID      <= (state_nxt == S_RESP);
         CMD_READY      <= (state_nxt == S_IDLE);
         BUSY           <= (state_nxt != S_IDLE);
         FINEENABLE     <= (state_nxt == S_FINE_PULSE);
         FINEINC        <= (state_nxt != S_IDLE) && fine_cmd_nxt && dir_nxt;
         COUNTERLOADEN  <= (state_nxt == S_LOAD_PULSE);
         COUNTERREADEN  <= (state_nxt == S_READ_PULSE);
      end
   end

endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
// tb/tb_phaser_in_tap_ctrl.sv - self-checking bench for phaser_in_tap_ctrl
// A per-cycle expectation table is built from command-level timing arithmetic and compared every cycle.
module tb_phaser_in_tap_ctrl;

   localparam int SETTLE = 8;
   localparam int RD_LAT = 4;
   localparam int INIT   = 0;
   localparam int DEPTH  = 4096;

   logic       SYSCLK;
   logic       RST;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic [5:0] CMD_ARG;
   logic       RSP_VALID;
   logic [5:0] RSP_DATA;
   logic       RSP_ERR;
   logic       BUSY;
   logic [5:0] FINE_TAP;
   logic       FINEENABLE;
   logic       FINEINC;
   logic       COUNTERLOADEN;
   logic [5:0] COUNTERLOADVAL;
   logic       COUNTERREADEN;
   logic [5:0] COUNTERREADVAL;
   logic       FINEOVERFLOW;

   phaser_in_tap_ctrl #(
      .SETTLE_CYCLES(SETTLE),
      .READ_LATENCY (RD_LAT),
      .INIT_FINE_TAP(INIT)
   ) dut (
      .SYSCLK        (SYSCLK),
      .RST           (RST),
      .CMD_VALID     (CMD_VALID),
      .CMD_READY     (CMD_READY),
      .CMD_OP        (CMD_OP),
      .CMD_ARG       (CMD_ARG),
      .RSP_VALID     (RSP_VALID),
      .RSP_DATA      (RSP_DATA),
      .RSP_ERR       (RSP_ERR),
      .BUSY          (BUSY),
      .FINE_TAP      (FINE_TAP),
      .FINEENABLE    (FINEENABLE),
      .FINEINC       (FINEINC),
      .COUNTERLOADEN (COUNTERLOADEN),
      .COUNTERLOADVAL(COUNTERLOADVAL),
      .COUNTERREADEN (COUNTERREADEN),
      .COUNTERREADVAL(COUNTERREADVAL),
      .FINEOVERFLOW  (FINEOVERFLOW)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   int errs;
   int checks;
   int cyc;

   bit chk      [DEPTH];
   bit chk_finc [DEPTH];
   int e_fe     [DEPTH];
   int e_finc   [DEPTH];
   int e_le     [DEPTH];
   int e_re     [DEPTH];
   int e_rv     [DEPTH];
   int e_ready  [DEPTH];
   int e_busy   [DEPTH];
   int e_tap    [DEPTH];
   int e_load   [DEPTH];
   int e_rdata  [DEPTH];
   int e_rerr   [DEPTH];

   // Architectural state the model carries between commands.
   int m_tap, m_load, m_rdata, m_rerr;
   int rd_val;
   int last_t;

   int mon_rsp_n, mon_rsp_cyc, mon_rsp_data, mon_rsp_err;
   int mon_fe_n, mon_le_cyc, mon_re_cyc;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic set_idle(input int c);
      chk[c]      = 1'b1;
      chk_finc[c] = 1'b1;
      e_fe[c]     = 0;
      e_finc[c]   = 0;
      e_le[c]     = 0;
      e_re[c]     = 0;
      e_rv[c]     = 0;
      e_ready[c]  = 1;
      e_busy[c]   = 0;
      e_tap[c]    = m_tap;
      e_load[c]   = m_load;
      e_rdata[c]  = m_rdata;
      e_rerr[c]   = m_rerr;
   endtask

   // Compare the current cycle at the falling edge, then advance to just after the next rising edge.
   task automatic step();
      @(negedge SYSCLK);
      if (cyc < DEPTH && chk[cyc]) begin
         check("FINEENABLE", FINEENABLE, e_fe[cyc]);
         if (chk_finc[cyc]) check("FINEINC", FINEINC, e_finc[cyc]);
         check("COUNTERLOADEN", COUNTERLOADEN, e_le[cyc]);
         check("COUNTERLOADVAL", COUNTERLOADVAL, e_load[cyc]);
         check("COUNTERREADEN", COUNTERREADEN, e_re[cyc]);
         check("RSP_VALID", RSP_VALID, e_rv[cyc]);
         check("RSP_DATA", RSP_DATA, e_rdata[cyc]);
         check("RSP_ERR", RSP_ERR, e_rerr[cyc]);
         check("CMD_READY", CMD_READY, e_ready[cyc]);
         check("BUSY", BUSY, e_busy[cyc]);
         check("FINE_TAP", FINE_TAP, e_tap[cyc]);
      end
      if (RSP_VALID) begin
         mon_rsp_n++;
         mon_rsp_cyc  = cyc;
         mon_rsp_data = RSP_DATA;
         mon_rsp_err  = RSP_ERR;
      end
      if (FINEENABLE) mon_fe_n++;
      if (COUNTERLOADEN) mon_le_cyc = cyc;
      if (COUNTERREADEN) mon_re_cyc = cyc;
      @(posedge SYSCLK);
      #1;
      cyc++;
   endtask

   task automatic idle_for(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle(cyc);
         step();
      end
   endtask

   // ovf_rel / rst_rel: cycle offset from acceptance at which FINEOVERFLOW / RST is driven (<=0 = never).
   task automatic issue(input logic [1:0] op, input logic [5:0] arg, input int ovf_rel,
                        input bit hold, input int rst_rel);
      int t, s1, a, rsp, cnt, res, err, room, last, k;
      bit fine, dir;
      int tap0;
      t    = cyc;
      s1   = SETTLE + 1;
      a    = int'(arg);
      tap0 = m_tap;
      fine = (op[1] == 1'b0);
      dir  = (op == 2'b00);
      cnt  = 0;
      if (fine) begin
         room = dir ? 63 - tap0 : tap0;
         cnt  = (a < room) ? a : room;
         rsp  = t + 1 + cnt * s1;
         err  = (cnt < a) ? 1 : 0;
         if (ovf_rel > 0 && t + ovf_rel < rsp) begin
            cnt = (ovf_rel - 1) / s1 + 1;
            rsp = t + ovf_rel + 1;
            err = 1;
         end
         res = dir ? tap0 + cnt : tap0 - cnt;
      end else if (op == 2'b10) begin
         rsp = t + 2 + SETTLE;
         res = a;
         err = 0;
      end else begin
         rsp = t + 2 + RD_LAT;
         res = rd_val;
         err = 0;
      end
      last = (rst_rel > 0) ? t + rst_rel + 1 : rsp + 1;

      set_idle(t);
      for (int c = t + 1; c <= last; c++) begin
         if (rst_rel > 0 && c > t + rst_rel) begin
            m_tap = INIT; m_load = 0; m_rdata = 0; m_rerr = 0;
            set_idle(c);
         end else if (c > rsp) begin
            set_idle(c);
         end else begin
            chk[c]      = 1'b1;
            chk_finc[c] = 1'b0;
            e_fe[c] = 0; e_le[c] = 0; e_re[c] = 0; e_finc[c] = 0;
            e_rv[c]    = (c == rsp) ? 1 : 0;
            e_ready[c] = 0;
            e_busy[c]  = 1;
            if (fine) begin
               k     = (c < rsp) ? (c - t - 1) / s1 + 1 : cnt;
               m_tap = dir ? tap0 + k : tap0 - k;
               e_fe[c]     = (c < rsp && (c - t - 1) % s1 == 0) ? 1 : 0;
               chk_finc[c] = (c < rsp);
               e_finc[c]   = dir ? 1 : 0;
            end else if (op == 2'b10) begin
               e_le[c] = (c == t + 1) ? 1 : 0;
               if (c == t + 1) m_load = a;
            end else begin
               e_re[c] = (c == t + 1) ? 1 : 0;
            end
            if (c == rsp) begin
               m_rdata = res;
               m_rerr  = err;
            end
            e_tap[c]   = m_tap;
            e_load[c]  = m_load;
            e_rdata[c] = m_rdata;
            e_rerr[c]  = m_rerr;
         end
      end

      last_t    = t;
      mon_fe_n  = 0;
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      CMD_ARG   = arg;
      COUNTERREADVAL = 6'h15;
      for (int c = t + 1; c <= last; c++) begin
         step();
         if (hold) begin
            CMD_OP  = 2'($urandom);
            CMD_ARG = 6'($urandom);
         end else begin
            CMD_VALID = 1'b0;
         end
         FINEOVERFLOW   = (ovf_rel > 0 && c == t + ovf_rel);
         RST            = (rst_rel > 0 && c == t + rst_rel);
         COUNTERREADVAL = (op == 2'b11 && c >= t + 4) ? 6'(rd_val) : 6'h15;
      end
   endtask

   int rsp_before;

   initial begin
      errs = 0; checks = 0; cyc = 0;
      m_tap = INIT; m_load = 0; m_rdata = 0; m_rerr = 0;
      rd_val = 0; last_t = 0;
      mon_rsp_n = 0; mon_rsp_cyc = 0; mon_rsp_data = 0; mon_rsp_err = 0;
      mon_fe_n = 0; mon_le_cyc = 0; mon_re_cyc = 0;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_ARG = 6'd0;
      COUNTERREADVAL = 6'h15; FINEOVERFLOW = 1'b0;

      @(posedge SYSCLK);
      #1;
      cyc = 1;
      idle_for(1);
      RST = 1'b0;
      check("reset_ready", CMD_READY, 1);
      check("reset_tap", FINE_TAP, 0);
      idle_for(2);

      // Three increments, 9-cycle pulse spacing.
      issue(2'b00, 6'd3, 0, 1'b0, 0);
      check("inc3_latency", mon_rsp_cyc - last_t, 28);
      check("inc3_data", mon_rsp_data, 3);
      check("inc3_err", mon_rsp_err, 0);
      check("inc3_pulses", mon_fe_n, 3);
      check("inc3_ready_after", CMD_READY, 1);
      idle_for(1);

      // Upper limit reached mid-command, then already at the limit.
      issue(2'b00, 6'd59, 0, 1'b0, 0);
      issue(2'b00, 6'd4, 0, 1'b0, 0);
      check("inc_lim_latency", mon_rsp_cyc - last_t, 10);
      check("inc_lim_data", mon_rsp_data, 63);
      check("inc_lim_err", mon_rsp_err, 1);
      check("inc_lim_pulses", mon_fe_n, 1);
      issue(2'b00, 6'd1, 0, 1'b0, 0);
      check("inc_at63_latency", mon_rsp_cyc - last_t, 1);
      check("inc_at63_err", mon_rsp_err, 1);
      check("inc_at63_pulses", mon_fe_n, 0);

      // Overflow during the second settle window.
      issue(2'b01, 6'd43, 0, 1'b0, 0);
      issue(2'b01, 6'd5, 13, 1'b0, 0);
      check("ovf_latency", mon_rsp_cyc - last_t, 14);
      check("ovf_data", mon_rsp_data, 18);
      check("ovf_err", mon_rsp_err, 1);
      check("ovf_pulses", mon_fe_n, 2);
      issue(2'b01, 6'd0, 0, 1'b0, 0);
      check("dec0_latency", mon_rsp_cyc - last_t, 1);
      check("dec0_data", mon_rsp_data, 18);
      check("dec0_err", mon_rsp_err, 0);

      // Coarse counter load and read.
      issue(2'b10, 6'h2A, 0, 1'b0, 0);
      check("load_latency", mon_rsp_cyc - last_t, 10);
      check("load_pulse_cycle", mon_le_cyc - last_t, 1);
      check("load_data", mon_rsp_data, 8'h2A);
      rd_val = 6'h2A;
      issue(2'b11, 6'd0, 0, 1'b0, 0);
      check("read_latency", mon_rsp_cyc - last_t, 6);
      check("read_pulse_cycle", mon_re_cyc - last_t, 1);
      check("read_data", mon_rsp_data, 8'h2A);
      idle_for(2);
      rd_val = 6'h3F;
      issue(2'b11, 6'd9, 0, 1'b0, 0);

      // VALID held through busy periods; each next command is taken the cycle after RSP.
      issue(2'b10, 6'h11, 0, 1'b1, 0);
      issue(2'b00, 6'd2, 0, 1'b1, 0);
      issue(2'b10, 6'h05, 0, 1'b1, 0);
      rd_val = 6'h07;
      issue(2'b11, 6'd0, 0, 1'b0, 0);
      check("b2b_read_data", mon_rsp_data, 7);
      idle_for(1);

      // Lower limit reached mid-command, then already at zero.
      issue(2'b01, 6'd25, 0, 1'b0, 0);
      check("dec_lim_data", mon_rsp_data, 0);
      check("dec_lim_pulses", mon_fe_n, 20);
      issue(2'b01, 6'd1, 0, 1'b0, 0);
      check("dec_at0_err", mon_rsp_err, 1);

      // Reset in the first settle window of a long increment.
      rsp_before = mon_rsp_n;
      issue(2'b00, 6'd10, 0, 1'b0, 5);
      check("rst_tap", FINE_TAP, INIT);
      check("rst_ready", CMD_READY, 1);
      check("rst_fineenable", FINEENABLE, 0);
      check("rst_rsp_valid", RSP_VALID, 0);
      idle_for(3);
      check("rst_no_response", mon_rsp_n, rsp_before);

      issue(2'b10, 6'h33, 0, 1'b0, 0);
      issue(2'b00, 6'd1, 0, 1'b0, 0);
      check("post_rst_inc_data", mon_rsp_data, 1);
      idle_for(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/phaser_in_tap_ctrl.md
Name: phaser_in_tap_ctrl

Overview:
Command sequencer for one PHASER_IN instance's delay-control pins. It accepts fine-tap step, coarse counter load and counter read commands over a valid/ready handshake and drives FINEENABLE/FINEINC, COUNTERLOADEN/COUNTERLOADVAL and COUNTERREADEN with the required pulse widths and settle spacing. It tracks the current fine-tap position, guards the 0..63 range and FINEOVERFLOW, and returns one response per command. It sits between the memory-interface calibration logic and the PHASER_IN.

Parameters:
SETTLE_CYCLES, 8, idle cycles after every FINEENABLE or COUNTERLOADEN pulse (1..255)
READ_LATENCY, 4, cycles from the COUNTERREADEN pulse to the COUNTERREADVAL sample (1..15)
INIT_FINE_TAP, 0, fine-tap position after reset; must equal the PHASER_IN FINE_DELAY attribute (0..63)

Ports:
SYSCLK  in  1  single clock; also the PHASER_IN SYSCLK
RST  in  1  synchronous, active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  command accepted when VALID&READY
CMD_OP  in  2  00 FINE_INC, 01 FINE_DEC, 10 COUNTER_LOAD, 11 COUNTER_READ
CMD_ARG  in  6  tap count for FINE_*; load value for LOAD; ignored for READ
RSP_VALID  out  1  one-cycle response strobe
RSP_DATA  out  6  FINE_*: final FINE_TAP; LOAD: loaded value; READ: sampled value
RSP_ERR  out  1  valid with RSP_VALID; range limit hit or overflow abort
BUSY  out  1  high whenever state is not IDLE
FINE_TAP  out  6  tracked fine-tap position
FINEENABLE  out  1  to PHASER_IN
FINEINC  out  1  to PHASER_IN
COUNTERLOADEN  out  1  to PHASER_IN
COUNTERLOADVAL  out  6  to PHASER_IN
COUNTERREADEN  out  1  to PHASER_IN
COUNTERREADVAL  in  6  from PHASER_IN
FINEOVERFLOW  in  1  from PHASER_IN

Behaviour:
- Reset, sampled at the SYSCLK edge: state=IDLE; FINE_TAP=INIT_FINE_TAP; every other output=0, except CMD_READY=1 after reset. A reset during an operation abandons it, issues no response and leaves no pin pulse pending.
- All outputs are registered. CMD_READY=1 only in IDLE. The command is captured on the edge where VALID&READY is high; call that cycle T. CMD_VALID outside IDLE is ignored.
- States: IDLE, FINE_PULSE, FINE_WAIT, LOAD_PULSE, LOAD_WAIT, READ_PULSE, READ_WAIT, RESP.
- FINE_*:
  - remaining=ARG; dir=1 for INC, 0 for DEC.
  - If remaining==0, or FINE_TAP is already at the limit (63 for INC, 0 for DEC): RESP at T+1, with ERR=1 only when remaining!=0.
  - Otherwise FINE_PULSE for 1 cycle: FINEENABLE=1, FINEINC=dir; FINE_TAP±1 and remaining-1 on the same edge.
  - Then FINE_WAIT for SETTLE_CYCLES cycles with FINEENABLE=0. FINEINC holds dir throughout the command and returns to 0 in IDLE.
  - At the end of FINE_WAIT: remaining==0 → RESP, ERR=0; at limit with remaining!=0 → RESP, ERR=1; else the next FINE_PULSE.
  - Full N-step latency: RSP_VALID at T+1+N*(1+SETTLE_CYCLES).
- FINEOVERFLOW is sampled during FINE_WAIT and FINE_PULSE. If high, go to RESP on the next cycle with ERR=1, and FINE_TAP keeps all pulses already issued.
- COUNTER_LOAD:
  - LOAD_PULSE for 1 cycle: COUNTERLOADEN=1, COUNTERLOADVAL=ARG. COUNTERLOADVAL holds its value until the next load.
  - LOAD_WAIT for SETTLE_CYCLES cycles, then RESP with DATA=ARG, ERR=0, at T+2+SETTLE_CYCLES.
- COUNTER_READ:
  - READ_PULSE for 1 cycle: COUNTERREADEN=1.
  - READ_WAIT for READ_LATENCY cycles; COUNTERREADVAL is captured on the last READ_WAIT edge.
  - RESP with that value at T+2+READ_LATENCY.
- RESP: RSP_VALID=1 for exactly one cycle with DATA/ERR valid; the next cycle is IDLE with CMD_READY=1. RSP_DATA/RSP_ERR hold their values until the next RESP.
- Never more than one of FINEENABLE, COUNTERLOADEN, COUNTERREADEN is high in a cycle. FINEENABLE pulses are always at least SETTLE_CYCLES+1 cycles apart.

Test Plan:
1. Reset, INIT_FINE_TAP=0, SETTLE=8; FINE_INC ARG=3 accepted at T=0 → FINEENABLE=1 with FINEINC=1 at cycles 1, 10, 19 only; RSP_VALID at 28 with DATA=3, ERR=0; CMD_READY=1 at 29.
2. FINE_TAP=62, FINE_INC ARG=4 → exactly one pulse at cycle 1; RSP_VALID at 10 with DATA=63, ERR=1. Then FINE_INC ARG=1 → no pulse; RSP one cycle after accept with ERR=1.
3. FINE_DEC ARG=5 from tap 20; FINEOVERFLOW=1 during the second FINE_WAIT → 2 pulses total; RSP next cycle with DATA=18, ERR=1. FINE_DEC ARG=0 → RSP at T+1 with DATA=18, ERR=0.
4. COUNTER_LOAD ARG=0x2A → COUNTERLOADEN high 1 cycle with VAL=0x2A; RSP at T+10 with DATA=0x2A. Then COUNTER_READ with the bench driving COUNTERREADVAL=0x2A three cycles after COUNTERREADEN → RSP at T+6 with DATA=0x2A.
5. CMD_VALID held high with changing OP while BUSY → no second acceptance; back-to-back commands are accepted one cycle after each RSP.
6. RST asserted mid FINE_WAIT of FINE_INC ARG=10 → next cycle all pins 0, FINE_TAP=INIT_FINE_TAP, no RSP_VALID, CMD_READY=1.
